// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite register master.
// Contents: FSM state enum, AXI response codes, the IP register offsets,
// and a helper that sizes the per-phase timeout counter.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_B,
    RD_A,
    RD_R,
    RSP
  } axil_mst_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;

  // Counter must hold TIMEOUT_CYCLES and is never narrower than 8 bits.
  function automatic int unsigned timer_width(input int unsigned timeout_cycles);
    int unsigned w;
    w = $clog2(timeout_cycles + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/axil_phase_timer.sv
// Per-phase watchdog for the AXI4-Lite master.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   i_clear      restart the count (not in a timed phase, or the phase is finishing)
//   o_expire_c   combinational: the current cycle is the last one allowed in this phase
// TIMEOUT_CYCLES = 0 disables expiry.
module axil_phase_timer
  import axil_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_expire_c
);

  localparam int unsigned CW    = timer_width(TIMEOUT_CYCLES);
  localparam int unsigned LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  logic [CW-1:0] r_cnt;

  // Count holds at the limit so it can never wrap back into range.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (!o_expire_c) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Expiry is flagged while counting the last allowed cycle, so the abort
  // edge is exactly TIMEOUT_CYCLES cycles after phase entry.
  assign o_expire_c = (TIMEOUT_CYCLES != 0) && (r_cnt == CW'(LIMIT));

endmodule

// File: rtl/axil_master_ctrl.sv
// AXI4-Lite initiator: turns single register commands from the control
// sequencer into AXI-Lite write/read transactions, one response per command.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/ready/we/addr/wdata   command channel (accepted in IDLE only)
//   rsp_valid/ready/rdata/resp/timeout  response channel (held until consumed)
//   m_axi_aw*/w*/b*/ar*/r*    AXI4-Lite master interface
module axil_master_ctrl
  import axil_pkg::*;
#(
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 4,
  parameter int unsigned TIMEOUT_CYCLES     = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_we,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                        m_axi_awprot,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                        m_axi_arprot,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready
);

  axil_mst_state_e r_state;
  logic            r_aw_done;
  logic            r_w_done;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_wr_done;
  logic w_timed;
  logic w_adv;
  logic w_expire;
  logic w_abort;

  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wstrb  = '1;

  assign w_aw_hs   = m_axi_awvalid && m_axi_awready;
  assign w_w_hs    = m_axi_wvalid && m_axi_wready;
  assign w_wr_done = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

  // Which states are watched by the timer, and whether the phase completes this cycle.
  always_comb begin
    w_timed = 1'b0;
    w_adv   = 1'b0;
    case (r_state)
      WR:      begin w_timed = 1'b1; w_adv = w_wr_done;                     end
      WR_B:    begin w_timed = 1'b1; w_adv = m_axi_bvalid && m_axi_bready;  end
      RD_A:    begin w_timed = 1'b1; w_adv = m_axi_arvalid && m_axi_arready; end
      RD_R:    begin w_timed = 1'b1; w_adv = m_axi_rvalid && m_axi_rready;  end
      default: begin w_timed = 1'b0; w_adv = 1'b0;                          end
    endcase
  end

  // A slave response in the expiry cycle takes priority over the abort.
  assign w_abort = w_timed && w_expire && !w_adv;

  axil_phase_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (!w_timed || w_adv),
    .o_expire_c (w_expire)
  );

  // Transaction FSM with registered channel outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= RESP_OKAY;
      rsp_timeout   <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_we) begin
              r_state       <= WR;
              m_axi_awaddr  <= cmd_addr;
              m_axi_wdata   <= cmd_wdata;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              r_aw_done     <= 1'b0;
              r_w_done      <= 1'b0;
            end else begin
              r_state       <= RD_A;
              m_axi_araddr  <= cmd_addr;
              m_axi_arvalid <= 1'b1;
            end
          end
        end

        // AW and W complete independently, in any order.
        WR: begin
          if (w_aw_hs) begin
            m_axi_awvalid <= 1'b0;
            r_aw_done     <= 1'b1;
          end
          if (w_w_hs) begin
            m_axi_wvalid <= 1'b0;
            r_w_done     <= 1'b1;
          end
          if (w_wr_done) begin
            r_state      <= WR_B;
            m_axi_bready <= 1'b1;
          end
        end

        WR_B: begin
          if (m_axi_bvalid && m_axi_bready) begin
            r_state      <= RSP;
            m_axi_bready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= '0;
            rsp_resp     <= m_axi_bresp;
            rsp_timeout  <= 1'b0;
          end
        end

        RD_A: begin
          if (m_axi_arvalid && m_axi_arready) begin
            r_state       <= RD_R;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
          end
        end

        RD_R: begin
          if (m_axi_rvalid && m_axi_rready) begin
            r_state      <= RSP;
            m_axi_rready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            rsp_timeout  <= 1'b0;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= RESP_OKAY;
            rsp_timeout <= 1'b0;
            cmd_ready   <= 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase

      // Debug abort: drop every AXI handshake signal and report SLVERR.
      if (w_abort) begin
        r_state       <= RSP;
        m_axi_awvalid <= 1'b0;
        m_axi_wvalid  <= 1'b0;
        m_axi_bready  <= 1'b0;
        m_axi_arvalid <= 1'b0;
        m_axi_rready  <= 1'b0;
        rsp_valid     <= 1'b1;
        rsp_rdata     <= '0;
        rsp_resp      <= RESP_SLVERR;
        rsp_timeout   <= 1'b1;
      end
    end
  end

endmodule
